// File: rtl/photo_tape_emulator.sv
// Paper-tape reader emulator: replays a loaded 5-channel frame image on the
// photocell outputs, stepping forward/reverse one frame at a time or rewinding.
module photo_tape_emulator #(
    parameter int ADDR_W         = 12,
    parameter int CLKS_PER_FRAME = 430,
    parameter int HOLE_CLKS      = 215,
    parameter int REWIND_CLKS    = 22
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_we,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [4:0]        load_data,
    input  logic              load_end,
    input  logic              PL6_9_PHOTO_TAPE_FWD,
    input  logic              PL6_10_PHOTO_TAPE_REV,
    input  logic              PL6_11_REMOTE_REWIND,
    output logic              PL6_1_PHOTO1,
    output logic              PL6_2_PHOTO2,
    output logic              PL6_4_PHOTO3,
    output logic              PL6_5_PHOTO4,
    output logic              PL6_7_PHOTO5,
    output logic [ADDR_W:0]   tape_pos,
    output logic              at_start,
    output logic              at_end,
    output logic              moving
);
    localparam int PW = ADDR_W + 1;
    localparam int CW = $clog2(CLKS_PER_FRAME + REWIND_CLKS + 1);

    localparam logic [CW-1:0] FRAME_LAST = CW'(CLKS_PER_FRAME - 1);
    localparam logic [CW-1:0] HOLE_END   = CW'(HOLE_CLKS);
    localparam logic [CW-1:0] REW_LAST   = CW'(REWIND_CLKS - 1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    typedef enum logic [1:0] {IDLE, FWD, REV, REWIND} state_t;

    state_t            state, state_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [PW-1:0]     tape_len, len_n, pos_n;
    logic [4:0]        photo, photo_n;
    logic [4:0]        rd_data;
    logic [ADDR_W-1:0] rd_addr;
    logic              in_hole;
    logic [4:0]        mem [2**ADDR_W];

    // Request arbitration shared by IDLE and the end-of-frame decision.
    function automatic state_t next_dir(input logic [PW-1:0] pos,
                                        input logic [PW-1:0] len,
                                        input logic fwd, input logic rev,
                                        input logic rew);
        state_t s;
        s = IDLE;
        if (rew) begin
            if (pos != '0) s = REWIND;
        end else if (fwd && !rev) begin
            if (pos < len) s = FWD;
        end else if (rev && !fwd) begin
            if (pos != '0) s = REV;
        end
        return s;
    endfunction

    // Reverse motion shows the frame just behind the read head.
    assign rd_addr = (state == REV) ? tape_pos[ADDR_W-1:0] - ADDR_W'(1)
                                    : tape_pos[ADDR_W-1:0];

    always_ff @(posedge clk) begin
        if (load_we) mem[load_addr] <= load_data;
        rd_data <= mem[rd_addr];
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        pos_n   = tape_pos;
        len_n   = tape_len;
        photo_n = '0;
        in_hole = (cnt >= CNT_ONE) && (cnt <= HOLE_END);
        if (load_we && load_end) len_n = {1'b0, load_addr} + PW'(1);
        case (state)
            IDLE: begin
                cnt_n   = '0;
                state_n = next_dir(tape_pos, tape_len, PL6_9_PHOTO_TAPE_FWD,
                                   PL6_10_PHOTO_TAPE_REV, PL6_11_REMOTE_REWIND);
            end
            FWD, REV: begin
                if (PL6_11_REMOTE_REWIND) begin
                    state_n = REWIND;
                    cnt_n   = '0;
                end else begin
                    if (in_hole) photo_n = rd_data;
                    if (cnt == FRAME_LAST) begin
                        cnt_n = '0;
                        if (state == FWD) begin
                            if (tape_pos < tape_len) pos_n = tape_pos + PW'(1);
                        end else if (tape_pos != '0) begin
                            pos_n = tape_pos - PW'(1);
                        end
                        state_n = next_dir(pos_n, tape_len, PL6_9_PHOTO_TAPE_FWD,
                                           PL6_10_PHOTO_TAPE_REV, 1'b0);
                    end else begin
                        cnt_n = cnt + CNT_ONE;
                    end
                end
            end
            REWIND: begin
                if (tape_pos == '0) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (cnt == REW_LAST) begin
                    cnt_n = '0;
                    pos_n = tape_pos - PW'(1);
                    if (tape_pos == PW'(1)) state_n = IDLE;
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            tape_pos <= '0;
            tape_len <= '0;
            photo    <= '0;
            at_start <= 1'b1;
            at_end   <= 1'b1;
            moving   <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            tape_pos <= pos_n;
            tape_len <= len_n;
            photo    <= photo_n;
            at_start <= (pos_n == '0);
            at_end   <= (pos_n >= len_n);
            moving   <= (state_n != IDLE);
        end
    end

    assign PL6_1_PHOTO1 = photo[0];
    assign PL6_2_PHOTO2 = photo[1];
    assign PL6_4_PHOTO3 = photo[2];
    assign PL6_5_PHOTO4 = photo[3];
    assign PL6_7_PHOTO5 = photo[4];

endmodule

// File: tb/tb_photo_tape_emulator.sv
// Bench for photo_tape_emulator: directed scenarios plus random motion,
// checked every cycle against a frame-timing model of the tape.
module tb_photo_tape_emulator;
    localparam int AW   = 4;
    localparam int CPF  = 40;
    localparam int HOLE = 20;
    localparam int RWC  = 6;
    localparam int NMEM = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_we, load_end;
    logic [AW-1:0] load_addr;
    logic [4:0]    load_data;
    logic          fwd, rev, rew;
    logic          p1, p2, p3, p4, p5;
    logic [AW:0]   tape_pos;
    logic          at_start, at_end, moving;
    logic [4:0]    photo;

    int n_checks = 0;
    int n_fail   = 0;

    logic [4:0] mmem [NMEM];
    int         mpos;
    int         mlen;

    assign photo = {p5, p4, p3, p2, p1};

    always #5 clk = ~clk;

    photo_tape_emulator #(
        .ADDR_W(AW),
        .CLKS_PER_FRAME(CPF),
        .HOLE_CLKS(HOLE),
        .REWIND_CLKS(RWC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .load_we(load_we),
        .load_addr(load_addr),
        .load_data(load_data),
        .load_end(load_end),
        .PL6_9_PHOTO_TAPE_FWD(fwd),
        .PL6_10_PHOTO_TAPE_REV(rev),
        .PL6_11_REMOTE_REWIND(rew),
        .PL6_1_PHOTO1(p1),
        .PL6_2_PHOTO2(p2),
        .PL6_4_PHOTO3(p3),
        .PL6_5_PHOTO4(p4),
        .PL6_7_PHOTO5(p5),
        .tape_pos(tape_pos),
        .at_start(at_start),
        .at_end(at_end),
        .moving(moving)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_frame(input int addr, input logic [4:0] data, input bit is_end);
        load_we   = 1'b1;
        load_addr = addr[AW-1:0];
        load_data = data;
        load_end  = is_end;
        tick();
        load_we  = 1'b0;
        load_end = 1'b0;
        mmem[addr] = data;
        if (is_end) mlen = addr + 1;
    endtask

    // Hold a direction request for nreq frames (dropped drop_r clocks into
    // the last one); the model clips motion at the tape limits.
    task automatic do_move(input int dir, input int nreq, input int drop_r, input string tag);
        int avail, nf, t_end, f, r, k, exp_pos;
        logic [4:0] exp_ph;
        logic [AW:0] ep;
        bit exp_mv;
        avail = (dir == 0) ? ((mlen > mpos) ? mlen - mpos : 0) : mpos;
        nf    = (nreq < avail) ? nreq : avail;
        t_end = (nf == 0) ? 5 : nf * CPF + 3;
        if (dir == 0) fwd = 1'b1; else rev = 1'b1;
        for (int t = 0; t <= t_end; t++) begin
            tick();
            exp_ph = '0;
            if (t >= 1) begin
                f = (t - 1) / CPF;
                r = (t - 1) % CPF;
                if (f < nf && r >= 1 && r <= HOLE)
                    exp_ph = (dir == 0) ? mmem[mpos + f] : mmem[mpos - 1 - f];
            end
            k = t / CPF;
            if (k > nf) k = nf;
            exp_pos = (dir == 0) ? mpos + k : mpos - k;
            ep      = exp_pos[AW:0];
            exp_mv  = (t < nf * CPF);
            n_checks++;
            if (photo !== exp_ph) begin
                n_fail++;
                $display("FAIL %s photo t=%0d: got %h expected %h", tag, t, photo, exp_ph);
            end
            n_checks++;
            if (tape_pos !== ep) begin
                n_fail++;
                $display("FAIL %s tape_pos t=%0d: got %0d expected %0d", tag, t, tape_pos, ep);
            end
            n_checks++;
            if (moving !== exp_mv) begin
                n_fail++;
                $display("FAIL %s moving t=%0d: got %b expected %b", tag, t, moving, exp_mv);
            end
            n_checks++;
            if (at_start !== (exp_pos == 0)) begin
                n_fail++;
                $display("FAIL %s at_start t=%0d: got %b expected %b", tag, t, at_start, exp_pos == 0);
            end
            n_checks++;
            if (at_end !== (exp_pos >= mlen)) begin
                n_fail++;
                $display("FAIL %s at_end t=%0d: got %b expected %b", tag, t, at_end, exp_pos >= mlen);
            end
            if (t == (nreq - 1) * CPF + drop_r) begin
                fwd = 1'b0;
                rev = 1'b0;
            end
        end
        fwd  = 1'b0;
        rev  = 1'b0;
        mpos = (dir == 0) ? mpos + nf : mpos - nf;
    endtask

    task automatic do_rewind(input string tag);
        int start, n, k;
        logic [AW:0] ep;
        bit exp_mv;
        start = mpos;
        n     = start * RWC;
        rew   = 1'b1;
        for (int t = 0; t <= n + 3; t++) begin
            tick();
            if (t == 0) rew = 1'b0;
            k = t / RWC;
            if (k > start) k = start;
            ep     = 5'(start - k);
            exp_mv = (t < n);
            n_checks++;
            if (photo !== 5'h00) begin
                n_fail++;
                $display("FAIL %s photo t=%0d: got %h expected 00", tag, t, photo);
            end
            n_checks++;
            if (tape_pos !== ep) begin
                n_fail++;
                $display("FAIL %s tape_pos t=%0d: got %0d expected %0d", tag, t, tape_pos, ep);
            end
            n_checks++;
            if (moving !== exp_mv) begin
                n_fail++;
                $display("FAIL %s moving t=%0d: got %b expected %b", tag, t, moving, exp_mv);
            end
        end
        mpos = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1; load_we = 1'b0; load_end = 1'b0; load_addr = '0; load_data = '0;
        fwd = 1'b0; rev = 1'b0; rew = 1'b0;
        mpos = 0; mlen = 0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        n_checks++;
        if (photo !== 5'h00) begin n_fail++; $display("FAIL reset photo: got %h expected 00", photo); end
        n_checks++;
        if (tape_pos !== '0) begin n_fail++; $display("FAIL reset tape_pos: got %0d expected 0", tape_pos); end
        n_checks++;
        if (at_start !== 1'b1) begin n_fail++; $display("FAIL reset at_start: got %b expected 1", at_start); end
        n_checks++;
        if (at_end !== 1'b1) begin n_fail++; $display("FAIL reset at_end: got %b expected 1", at_end); end
        n_checks++;
        if (moving !== 1'b0) begin n_fail++; $display("FAIL reset moving: got %b expected 0", moving); end
    endtask

    task automatic test_fwd_basic();
        load_frame(0, 5'h01, 1'b0);
        load_frame(1, 5'h1F, 1'b0);
        load_frame(2, 5'h10, 1'b1);
        do_move(0, 5, 5, "fwd_basic");
    endtask

    task automatic test_rev_basic();
        do_move(1, 5, 5, "rev_basic");
    endtask

    task automatic test_fwd_drop();
        do_move(0, 1, 10, "fwd_drop");
    endtask

    task automatic test_both_requests();
        fwd = 1'b1;
        rev = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            tick();
            n_checks++;
            if (moving !== 1'b0 || photo !== 5'h00) begin
                n_fail++;
                $display("FAIL both_req cycle %0d: moving %b photo %h expected 0 00", i, moving, photo);
            end
        end
        fwd = 1'b0;
        rev = 1'b0;
    endtask

    task automatic test_rewind_abort();
        logic [AW:0] ep;
        do_move(0, 1, 5, "to_pos2");
        fwd = 1'b1;
        for (int t = 0; t <= 8; t++) tick();
        n_checks++;
        if (photo !== mmem[2]) begin
            n_fail++;
            $display("FAIL abort pre-photo: got %h expected %h", photo, mmem[2]);
        end
        fwd = 1'b0;
        rew = 1'b1;
        tick();
        rew = 1'b0;
        n_checks++;
        if (photo !== 5'h00 || moving !== 1'b1) begin
            n_fail++;
            $display("FAIL abort entry: photo %h moving %b expected 00 1", photo, moving);
        end
        for (int i = 1; i <= 2 * RWC; i++) begin
            tick();
            ep = 5'(2 - i / RWC);
            n_checks++;
            if (tape_pos !== ep || moving !== (i < 2 * RWC) || photo !== 5'h00) begin
                n_fail++;
                $display("FAIL abort rewind i=%0d: pos %0d moving %b photo %h expected %0d %b 00",
                         i, tape_pos, moving, photo, ep, i < 2 * RWC);
            end
        end
        n_checks++;
        if (at_start !== 1'b1) begin n_fail++; $display("FAIL abort at_start: got %b expected 1", at_start); end
        mpos = 0;
    endtask

    task automatic test_boundaries();
        do_move(1, 2, 5, "rev_at_start");
        do_rewind("rew_at_start");
        do_move(0, 3, 5, "fwd_full");
        load_frame(0, 5'h01, 1'b1);
        n_checks++;
        if (at_end !== 1'b1 || tape_pos !== 5'd3) begin
            n_fail++;
            $display("FAIL shrink_len: at_end %b pos %0d expected 1 3", at_end, tape_pos);
        end
        do_move(0, 1, 5, "fwd_beyond_len");
        do_move(1, 1, 7, "rev_over_len");
        do_rewind("rew_over_len");
        load_frame(2, 5'h10, 1'b1);
    endtask

    task automatic test_reset_async();
        fwd = 1'b1;
        for (int t = 0; t <= 4; t++) tick();
        n_checks++;
        if (photo !== mmem[0]) begin
            n_fail++;
            $display("FAIL async_rst pre-photo: got %h expected %h", photo, mmem[0]);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (photo !== 5'h00) begin n_fail++; $display("FAIL async_rst photo: got %h expected 00", photo); end
        n_checks++;
        if (tape_pos !== '0) begin n_fail++; $display("FAIL async_rst tape_pos: got %0d expected 0", tape_pos); end
        n_checks++;
        if (at_end !== 1'b1 || moving !== 1'b0) begin
            n_fail++;
            $display("FAIL async_rst flags: at_end %b moving %b expected 1 0", at_end, moving);
        end
        fwd = 1'b0;
        tick();
        rst  = 1'b0;
        mpos = 0;
        mlen = 0;
    endtask

    task automatic test_random();
        int len, op;
        len = $urandom_range(1, NMEM);
        for (int i = 0; i < NMEM; i++)
            load_frame(i, 5'($urandom), i == len - 1);
        for (int i = 0; i < 25; i++) begin
            op = $urandom_range(0, 9);
            if (op < 5)      do_move(0, $urandom_range(1, 6), $urandom_range(1, CPF - 1), "rand_fwd");
            else if (op < 9) do_move(1, $urandom_range(1, 6), $urandom_range(1, CPF - 1), "rand_rev");
            else             do_rewind("rand_rew");
        end
    endtask

    initial begin
        test_reset();
        test_fwd_basic();
        test_rev_basic();
        test_fwd_drop();
        test_both_requests();
        test_rewind_abort();
        test_boundaries();
        test_reset_async();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
